uart_cmd_parser: RTL and testbench

- Command controller that sits directly behind the UART receiver. It turns the receiver's per-byte outputs (ready, data, error) into register-write commands.
- Each packet is 4 bytes: SYNC, ADDR, DATA, CHK. A valid packet produces one write to a NUM_REGS-entry register port.
- Bad packets are rejected with an error code. A stalled packet is aborted by an inter-byte timeout.

---
 rtl/uart_cmd_parser.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Packet controller behind the UART receiver: SYNC, ADDR, DATA, CHK bytes become
// one register write. Bad or stalled packets are rejected with an error code.
//
// state  | meaning
// S_IDLE | hunting for SYNC_BYTE, other bytes dropped silently
// S_ADDR | SYNC seen, waiting for the address byte
// S_DATA | address stored, waiting for the data byte
// S_CHK  | data stored, waiting for the checksum byte
module uart_cmd_parser #(
  parameter int                     DATA_BITS      = 8,
  parameter int                     NUM_REGS       = 8,
  parameter logic [DATA_BITS-1:0]   SYNC_BYTE      = 8'hA5,
  parameter int                     TIMEOUT_CYCLES = 20000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_ready,
  input  logic [DATA_BITS-1:0]         rx_data,
  input  logic                         rx_error,
  output logic                         reg_we,
  output logic [$clog2(NUM_REGS)-1:0]  reg_addr,
  output logic [DATA_BITS-1:0]         reg_wdata,
  output logic                         busy,
  output logic                         pkt_ok,
  output logic                         pkt_err,
  output logic [1:0]                   err_code
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_RX      = 2'd1;
  localparam logic [1:0] ERR_CHKSUM  = 2'd2;
  localparam logic [1:0] ERR_RANGE   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CHK} state_t;

  state_t               state_q, state_d;
  logic                 rdy_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] addr_byte_q, addr_byte_d;
  logic [DATA_BITS-1:0] data_byte_q, data_byte_d;
  logic                 reg_we_q, reg_we_d;
  logic [AW-1:0]        reg_addr_q, reg_addr_d;
  logic [DATA_BITS-1:0] reg_wdata_q, reg_wdata_d;
  logic                 pkt_ok_q, pkt_ok_d;
  logic                 pkt_err_q, pkt_err_d;
  logic [1:0]           err_code_q, err_code_d;

  logic                 strobe;
  logic                 cnt_tc;
  logic [DATA_BITS-1:0] chk_sum;

  // rdy_q resets high so a receiver that is idle at reset release gives no strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rdy_q       <= 1'b1;
      cnt_q       <= '0;
      addr_byte_q <= '0;
      data_byte_q <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= ERR_TIMEOUT;
    end else begin
      state_q     <= state_d;
      rdy_q       <= rx_ready;
      cnt_q       <= cnt_d;
      addr_byte_q <= addr_byte_d;
      data_byte_q <= data_byte_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    strobe      = rx_ready && !rdy_q;
    cnt_tc      = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    chk_sum     = addr_byte_q + data_byte_q;

    state_d     = state_q;
    addr_byte_d = addr_byte_q;
    data_byte_d = data_byte_q;
    cnt_d       = (state_q == S_IDLE || strobe) ? '0 : cnt_q + CW'(1);
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      S_IDLE: begin
        if (strobe && !rx_error && rx_data == SYNC_BYTE) state_d = S_ADDR;
      end
      S_ADDR, S_DATA, S_CHK: begin
        // A strobe on the terminal-count cycle takes precedence over the timeout
        if (strobe) begin
          if (rx_error) begin
            state_d    = S_IDLE;
            pkt_err_d  = 1'b1;
            err_code_d = ERR_RX;
          end else begin
            case (state_q)
              S_ADDR: begin
                addr_byte_d = rx_data;
                state_d     = S_DATA;
              end
              S_DATA: begin
                data_byte_d = rx_data;
                state_d     = S_CHK;
              end
              default: begin
                state_d = S_IDLE;
                if (rx_data != chk_sum) begin
                  pkt_err_d  = 1'b1;
                  err_code_d = ERR_CHKSUM;
                end else if ((addr_byte_q >> AW) != '0) begin
                  pkt_err_d  = 1'b1;
                  err_code_d = ERR_RANGE;
                end else begin
                  reg_we_d    = 1'b1;
                  pkt_ok_d    = 1'b1;
                  reg_addr_d  = addr_byte_q[AW-1:0];
                  reg_wdata_d = data_byte_q;
                end
              end
            endcase
          end
        end else if (cnt_tc) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          pkt_err_d  = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed packet scenarios plus randomized packets
// checked against a packet-level model of the accept/reject rules.
module tb_uart_cmd_parser;

  localparam int          DB   = 8;
  localparam int          NR   = 8;
  localparam int          TC   = 100;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_error = 1'b0;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        busy;
  logic        pkt_ok;
  logic        pkt_err;
  logic [1:0]  err_code;

  int          checks = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          n_err = 0;
  logic [1:0]  m_code = 2'd0;
  logic [2:0]  m_addr = 3'd0;
  logic [7:0]  m_wdata = 8'h00;

  uart_cmd_parser #(
    .DATA_BITS(DB), .NUM_REGS(NR), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_error(rx_error), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .busy(busy), .pkt_ok(pkt_ok), .pkt_err(pkt_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pkt_err === 1'b1) n_err <= n_err + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  // Frame is low for low_cycles, then rx_ready rises with the byte; the
  // strobe is sampled at the next posedge, i.e. cyc+1 when this returns.
  task automatic send_byte(input logic [7:0] b, input logic e, input int low_cycles);
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
    rx_error = 1'($urandom);
    repeat (low_cycles) @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    rx_error = e;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({reg_we, reg_addr, reg_wdata, busy, pkt_ok, pkt_err, err_code} !== 17'd0) begin
      fails++; $display("FAIL reset_values: got %h expected 0", {reg_we, reg_addr, reg_wdata, busy, pkt_ok, pkt_err, err_code}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({reg_we, busy, pkt_ok, pkt_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_release: flags=%b expected 0000", {reg_we, busy, pkt_ok, pkt_err}); end
  endtask

  task automatic test_valid();
    send_byte(SYNC, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_ok, pkt_err, busy} !== 4'b0001) begin
      fails++; $display("FAIL valid_sync_busy: flags=%b expected 0001", {reg_we, pkt_ok, pkt_err, busy}); end
    send_byte(8'h03, 1'b0, 1);
    send_byte(8'h5C, 1'b0, 2);
    send_byte(8'h5F, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_ok, pkt_err, busy} !== 4'b1100) begin
      fails++; $display("FAIL valid_accept: flags=%b expected 1100", {reg_we, pkt_ok, pkt_err, busy}); end
    checks++; if ({reg_addr, reg_wdata} !== {3'd3, 8'h5C}) begin
      fails++; $display("FAIL valid_write: addr/data=%h expected %h", {reg_addr, reg_wdata}, {3'd3, 8'h5C}); end
    @(negedge clk);
    checks++; if ({reg_we, pkt_ok, reg_addr, reg_wdata} !== {2'b00, 3'd3, 8'h5C}) begin
      fails++; $display("FAIL valid_one_cycle: we/ok/addr/data=%h expected %h", {reg_we, pkt_ok, reg_addr, reg_wdata}, {2'b00, 3'd3, 8'h5C}); end
    m_addr = 3'd3; m_wdata = 8'h5C;
  endtask

  task automatic test_checksum();
    send_byte(SYNC, 1'b0, 1); send_byte(8'h03, 1'b0, 1);
    send_byte(8'h5C, 1'b0, 1); send_byte(8'h00, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_ok, pkt_err, busy, err_code} !== {4'b0010, 2'd2}) begin
      fails++; $display("FAIL chk_reject: flags/code=%b expected 001010", {reg_we, pkt_ok, pkt_err, busy, err_code}); end
    @(negedge clk);
    checks++; if ({pkt_err, err_code, reg_addr, reg_wdata} !== {1'b0, 2'd2, m_addr, m_wdata}) begin
      fails++; $display("FAIL chk_hold: got %h expected %h", {pkt_err, err_code, reg_addr, reg_wdata}, {1'b0, 2'd2, m_addr, m_wdata}); end
    m_code = 2'd2;
    send_byte(SYNC, 1'b0, 1); send_byte(8'h01, 1'b0, 1);
    send_byte(8'h02, 1'b0, 1); send_byte(8'h03, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_ok, reg_addr, reg_wdata, err_code} !== {2'b11, 3'd1, 8'h02, 2'd2}) begin
      fails++; $display("FAIL chk_recover: got %h expected %h", {reg_we, pkt_ok, reg_addr, reg_wdata, err_code}, {2'b11, 3'd1, 8'h02, 2'd2}); end
    m_addr = 3'd1; m_wdata = 8'h02;
  endtask

  task automatic test_noise();
    int e0;
    e0 = n_err;
    send_byte(8'h12, 1'b0, 1); @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL noise_12: busy=%b expected 0", busy); end
    send_byte(8'h34, 1'b0, 1); @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL noise_34: busy=%b expected 0", busy); end
    send_byte(SYNC, 1'b1, 1); @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL noise_bad_sync: busy=%b expected 0", busy); end
    send_byte(SYNC, 1'b0, 1); send_byte(8'h07, 1'b0, 1);
    send_byte(8'h10, 1'b0, 1); send_byte(8'h17, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, reg_addr, reg_wdata, err_code} !== {1'b1, 3'd7, 8'h10, m_code}) begin
      fails++; $display("FAIL noise_accept: got %h expected %h", {reg_we, reg_addr, reg_wdata, err_code}, {1'b1, 3'd7, 8'h10, m_code}); end
    checks++; if (n_err !== e0) begin fails++; $display("FAIL noise_no_err: pkt_err pulses=%0d expected %0d", n_err - e0, 0); end
    m_addr = 3'd7; m_wdata = 8'h10;
  endtask

  task automatic test_priority();
    send_byte(SYNC, 1'b0, 1); send_byte(8'h09, 1'b0, 1);
    send_byte(8'h11, 1'b0, 1); send_byte(8'h1A, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_err, err_code} !== {2'b01, 2'd3}) begin
      fails++; $display("FAIL prio_range: we/err/code=%b expected 0111", {reg_we, pkt_err, err_code}); end
    send_byte(SYNC, 1'b0, 1); send_byte(8'h09, 1'b0, 1);
    send_byte(8'h11, 1'b0, 1); send_byte(8'h00, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_err, err_code} !== {2'b01, 2'd2}) begin
      fails++; $display("FAIL prio_chk_over_range: we/err/code=%b expected 0110", {reg_we, pkt_err, err_code}); end
    send_byte(SYNC, 1'b0, 1); send_byte(8'h04, 1'b0, 1);
    send_byte(8'h55, 1'b1, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_err, busy, err_code} !== {3'b010, 2'd1}) begin
      fails++; $display("FAIL prio_rx_error: we/err/busy/code=%b expected 01001", {reg_we, pkt_err, busy, err_code}); end
    m_code = 2'd1;
  endtask

  task automatic test_timeout();
    int unsigned s;
    send_byte(SYNC, 1'b0, 1); send_byte(8'h03, 1'b0, 1);
    s = cyc + 1;
    @(negedge clk);
    while (pkt_err !== 1'b1 && cyc < s + 300) @(negedge clk);
    checks++; if (cyc - s != TC) begin
      fails++; $display("FAIL timeout_latency: pkt_err %0d cycles after strobe expected %0d", cyc - s, TC); end
    checks++; if ({busy, err_code} !== 3'b000) begin
      fails++; $display("FAIL timeout_code: busy/code=%b expected 000", {busy, err_code}); end
    // strobe landing on the terminal-count cycle wins over the timeout
    send_byte(SYNC, 1'b0, 1); send_byte(8'h03, 1'b0, 1);
    s = cyc + 1;
    @(negedge clk);
    while (cyc < s + TC - 3) @(negedge clk);
    send_byte(8'h5C, 1'b0, 1); @(negedge clk);
    checks++; if ({pkt_err, busy} !== 2'b01 || cyc != s + TC) begin
      fails++; $display("FAIL timeout_edge_strobe: err/busy=%b at +%0d expected 01 at +%0d", {pkt_err, busy}, cyc - s, TC); end
    send_byte(8'h5F, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, reg_addr, reg_wdata} !== {1'b1, 3'd3, 8'h5C}) begin
      fails++; $display("FAIL timeout_edge_accept: got %h expected %h", {reg_we, reg_addr, reg_wdata}, {1'b1, 3'd3, 8'h5C}); end
    m_code = 2'd0; m_addr = 3'd3; m_wdata = 8'h5C;
  endtask

  task automatic test_reset_mid();
    int e0;
    send_byte(SYNC, 1'b0, 1); send_byte(8'h03, 1'b0, 1); @(negedge clk);
    e0 = n_err;
    rst_n = 1'b0; #1;
    checks++; if ({reg_we, reg_addr, reg_wdata, busy, pkt_ok, pkt_err, err_code} !== 17'd0) begin
      fails++; $display("FAIL reset_mid_async: got %h expected 0", {reg_we, reg_addr, reg_wdata, busy, pkt_ok, pkt_err, err_code}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (n_err !== e0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid_no_err: pulses=%0d busy=%b expected 0 0", n_err - e0, busy); end
    m_code = 2'd0; m_addr = 3'd0; m_wdata = 8'h00;
    send_byte(SYNC, 1'b0, 1); send_byte(8'h02, 1'b0, 1);
    send_byte(8'hAA, 1'b0, 1); send_byte(8'hAC, 1'b0, 1); @(negedge clk);
    checks++; if ({reg_we, pkt_ok, reg_addr, reg_wdata} !== {2'b11, 3'd2, 8'hAA}) begin
      fails++; $display("FAIL reset_mid_accept: got %h expected %h", {reg_we, pkt_ok, reg_addr, reg_wdata}, {2'b11, 3'd2, 8'hAA}); end
    m_addr = 3'd2; m_wdata = 8'hAA;
  endtask

  // Packet-level model: a rx_error byte aborts at once (code 1); otherwise
  // the checksum rule (code 2) beats the address range rule (code 3).
  task automatic test_random();
    logic [7:0] a, d, c, b;
    logic [3:0] exp_flags;
    logic [1:0] exp_code;
    int ep, low;
    bit fin;
    for (int p = 0; p < 60; p++) begin
      a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d   = 8'($urandom);
      c   = ($urandom_range(0, 9) < 7) ? 8'((a + d) % 256) : 8'($urandom);
      ep  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      low = $urandom_range(1, 3);
      send_byte(SYNC, 1'b0, low);
      for (int i = 1; i <= 3; i++) begin
        b = (i == 1) ? a : (i == 2) ? d : c;
        send_byte(b, 1'(ep == i), low);
        @(negedge clk);
        fin = 1'b1;
        exp_code = m_code;
        if (ep == i) begin
          exp_flags = 4'b0010; exp_code = 2'd1;
        end else if (i < 3) begin
          exp_flags = 4'b0001; fin = 1'b0;
        end else if (c != 8'((a + d) % 256)) begin
          exp_flags = 4'b0010; exp_code = 2'd2;
        end else if (a >= NR) begin
          exp_flags = 4'b0010; exp_code = 2'd3;
        end else begin
          exp_flags = 4'b1100; m_addr = a[2:0]; m_wdata = d;
        end
        checks++; if ({reg_we, pkt_ok, pkt_err, busy} !== exp_flags) begin
          fails++; $display("FAIL rand_flags pkt%0d byte%0d: flags=%b expected %b", p, i, {reg_we, pkt_ok, pkt_err, busy}, exp_flags); end
        if (fin) begin
          m_code = exp_code;
          checks++; if ({err_code, reg_addr, reg_wdata} !== {m_code, m_addr, m_wdata}) begin
            fails++; $display("FAIL rand_result pkt%0d: code/addr/data=%h expected %h", p, {err_code, reg_addr, reg_wdata}, {m_code, m_addr, m_wdata}); end
          break;
        end
      end
      @(negedge clk);
      checks++; if ({reg_we, pkt_ok, pkt_err, busy} !== 4'b0000) begin
        fails++; $display("FAIL rand_idle pkt%0d: flags=%b expected 0000", p, {reg_we, pkt_ok, pkt_err, busy}); end
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_checksum();
    test_noise();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
